// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : count_sequencer
//  Description : Rate-divided controller for an 8-bit toggle-flip-flop
//                counter. Produces the counter's toggle enable and its
//                active-low clear, handles start/stop/single-step commands,
//                and either halts or wraps when the count reaches a
//                programmable terminal value.
//  Revision    : 1.0  initial release
// ============================================================================
module count_sequencer #(
    parameter int DIV_WIDTH = 26
) (
    input  logic                 clk,
    input  logic                 clear_b,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    input  logic [DIV_WIDTH-1:0] div_max,
    input  logic [7:0]           limit,
    input  logic                 wrap,
    input  logic [7:0]           Q,
    output logic                 t,
    output logic                 cnt_clear_b,
    output logic                 running,
    output logic                 done,
    output logic                 wrapped
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLR  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [DIV_WIDTH-1:0] c_div_zero = '0;
    localparam logic [DIV_WIDTH-1:0] c_div_one  = DIV_WIDTH'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] w_div_nxt;
    logic [DIV_WIDTH-1:0] w_div_eff;
    logic                 w_tick;
    logic                 w_at_limit;

    logic                 w_t_nxt;
    logic                 w_clr_b_nxt;
    logic                 w_running_nxt;
    logic                 w_done_nxt;
    logic                 w_wrapped_nxt;

    // A divider of 0 would let t fire on back-to-back cycles, so the
    // smallest usable period is two cycles. A ">=" compare keeps the
    // divider from running away if div_max is lowered mid-period.
    assign w_div_eff  = (div_max <= c_div_one) ? c_div_one : div_max;
    assign w_tick     = (r_state == S_RUN) && (r_div >= w_div_eff);
    assign w_at_limit = (Q == limit);

    // State, divider and registered outputs; reset holds the counter clear.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            r_state     <= S_IDLE;
            r_div       <= c_div_zero;
            t           <= 1'b0;
            cnt_clear_b <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            wrapped     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            t           <= w_t_nxt;
            cnt_clear_b <= w_clr_b_nxt;
            running     <= w_running_nxt;
            done        <= w_done_nxt;
            wrapped     <= w_wrapped_nxt;
        end
    end

    // Next state and divider; stop beats start beats step in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = c_div_zero;
        case (r_state)
            S_IDLE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_CLR;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_CLR;
                end else if (w_tick) begin
                    if (w_at_limit && !wrap) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_div_nxt = r_div + c_div_one;
                end
            end
            S_DONE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_CLR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, decided from the current state.
    always_comb begin
        w_t_nxt       = 1'b0;
        w_clr_b_nxt   = 1'b1;
        w_done_nxt    = 1'b0;
        w_wrapped_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!stop) begin
                    if (start) begin
                        w_clr_b_nxt = 1'b0;
                    end else if (step) begin
                        // Manual increment: no terminal-value check here.
                        w_t_nxt = 1'b1;
                    end
                end
            end
            S_CLR: begin
                if (!stop && start) begin
                    w_clr_b_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (!stop) begin
                    if (start) begin
                        w_clr_b_nxt = 1'b0;
                    end else if (w_tick) begin
                        if (!w_at_limit) begin
                            w_t_nxt = 1'b1;
                        end else if (!wrap) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            // Clear instead of incrementing, so the count
                            // never reaches the counter's own rollover.
                            w_clr_b_nxt   = 1'b0;
                            w_wrapped_nxt = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (!stop && start) begin
                    w_clr_b_nxt = 1'b0;
                end
            end
            default: begin
                w_clr_b_nxt = 1'b1;
            end
        endcase
        w_running_nxt = (w_state_nxt == S_CLR) || (w_state_nxt == S_RUN);
    end

endmodule
`default_nettype wire
